bcd_tick_counter: RTL and testbench

- Two-digit BCD up/down counter with Start/Pause/Clear control.
- Sits directly downstream of the frequency divider: takes the divider's slow square wave on `Tick`, synchronises and edge-detects it in the `CLK` domain, and advances one count per rising edge of `Tick` while running.
- Drives the board's two-digit display: BCD digits always, seven-segment patterns when configured in.

---
 rtl/bcd_tick_counter_pkg.sv | 43 ++++
 rtl/bcd_to_seg7.sv | 24 ++
 rtl/bcd_tick_counter.sv | 155 +++++++++++++++
 tb/tb_bcd_tick_counter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_tick_counter_pkg.sv
// Shared types and constants for the two-digit BCD tick counter.
// Segment encoding is gfedcba, active-high.
package bcd_tick_counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned SEG_W   = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

  // Digit to segment pattern; non-decimal codes are blank.
  function automatic logic [SEG_W-1:0] seg7_encode(input logic [DIGIT_W-1:0] digit);
    case (digit)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Registered BCD digit to seven-segment decoder; resets to the "0" pattern.
module bcd_to_seg7
  import bcd_tick_counter_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [SEG_W-1:0]   o_seg
);

  logic [SEG_W-1:0] r_seg;

  // Register the decoded pattern so segments lag the digit by one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_seg <= SEG_0;
    end else begin
      r_seg <= seg7_encode(i_digit);
    end
  end

  assign o_seg = r_seg;

endmodule

// File: rtl/bcd_tick_counter.sv
// Two-digit BCD up/down counter advanced by rising edges of an asynchronous
// Tick, with Start/Pause/Clear control. Seven-segment outputs are built only
// when BCD_TICK_COUNTER_SEG7_EN is defined; otherwise they are tied to 0.
module bcd_tick_counter
  import bcd_tick_counter_pkg::*;
#(
  parameter int MAX_COUNT   = 59,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic               Tick,
  input  logic               Start,
  input  logic               Pause,
  input  logic               Clear,
  input  logic               Down,
  output logic [DIGIT_W-1:0] CountOnes,
  output logic [DIGIT_W-1:0] CountTens,
  output logic               Running,
  output logic               Wrap,
  output logic [SEG_W-1:0]   Seg7Ones,
  output logic [SEG_W-1:0]   Seg7Tens
);

  generate
    if (MAX_COUNT < 1 || MAX_COUNT > 99) begin : g_bad_max_count
      $error("bcd_tick_counter: MAX_COUNT must be in 1..99");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
      $error("bcd_tick_counter: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  localparam logic [DIGIT_W-1:0] MAX_TENS = DIGIT_W'(MAX_COUNT / 10);
  localparam logic [DIGIT_W-1:0] MAX_ONES = DIGIT_W'(MAX_COUNT % 10);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;
  logic                   w_step;
  state_t                 r_state;
  logic [DIGIT_W-1:0]     r_ones;
  logic [DIGIT_W-1:0]     r_tens;
  logic                   r_running;
  logic                   r_wrap;
  logic [SEG_W-1:0]       w_seg_ones;
  logic [SEG_W-1:0]       w_seg_tens;

  // Synchronise Tick and keep one history bit for rising-edge detection.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], Tick};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_step = r_sync[SYNC_STAGES-1] & ~r_hist;

  // Control FSM and BCD count; a step is only taken in RUN with no Clear/Pause.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_IDLE;
      r_ones    <= '0;
      r_tens    <= '0;
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_wrap <= 1'b0;
      if (Clear) begin
        r_state   <= ST_IDLE;
        r_ones    <= '0;
        r_tens    <= '0;
        r_running <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (Start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          ST_RUN: begin
            if (Pause) begin
              r_state   <= ST_PAUSE;
              r_running <= 1'b0;
            end else if (w_step) begin
              if (!Down) begin
                if (r_tens == MAX_TENS && r_ones == MAX_ONES) begin
                  r_tens <= '0;
                  r_ones <= '0;
                  r_wrap <= 1'b1;
                end else if (r_ones == 4'd9) begin
                  r_ones <= '0;
                  r_tens <= r_tens + 4'd1;
                end else begin
                  r_ones <= r_ones + 4'd1;
                end
              end else begin
                if (r_tens == '0 && r_ones == '0) begin
                  r_tens <= MAX_TENS;
                  r_ones <= MAX_ONES;
                  r_wrap <= 1'b1;
                end else if (r_ones == '0) begin
                  r_ones <= 4'd9;
                  r_tens <= r_tens - 4'd1;
                end else begin
                  r_ones <= r_ones - 4'd1;
                end
              end
            end
          end
          ST_PAUSE: begin
            if (Start) begin
              r_state   <= ST_RUN;
              r_running <= 1'b1;
            end
          end
          default: begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef BCD_TICK_COUNTER_SEG7_EN
  bcd_to_seg7 u_seg_ones (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_digit (r_ones),
    .o_seg   (w_seg_ones)
  );

  bcd_to_seg7 u_seg_tens (
    .i_clk   (CLK),
    .i_rst_n (nRST),
    .i_digit (r_tens),
    .o_seg   (w_seg_tens)
  );
`else
  assign w_seg_ones = '0;
  assign w_seg_tens = '0;
`endif

  assign CountOnes = r_ones;
  assign CountTens = r_tens;
  assign Running   = r_running;
  assign Wrap      = r_wrap;
  assign Seg7Ones  = w_seg_ones;
  assign Seg7Tens  = w_seg_tens;

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed self-checking bench for bcd_tick_counter (MAX_COUNT=59, SYNC_STAGES=2).
module tb_bcd_tick_counter;

  localparam int S = 2;

  logic       CLK   = 1'b0;
  logic       nRST  = 1'b0;
  logic       Tick  = 1'b0;
  logic       Start = 1'b0;
  logic       Pause = 1'b0;
  logic       Clear = 1'b0;
  logic       Down  = 1'b0;
  logic [3:0] CountOnes;
  logic [3:0] CountTens;
  logic       Running;
  logic       Wrap;
  logic [6:0] Seg7Ones;
  logic [6:0] Seg7Tens;

  int checks = 0;
  int errors = 0;

  bcd_tick_counter #(.MAX_COUNT(59), .SYNC_STAGES(S)) dut (
    .CLK       (CLK),
    .nRST      (nRST),
    .Tick      (Tick),
    .Start     (Start),
    .Pause     (Pause),
    .Clear     (Clear),
    .Down      (Down),
    .CountOnes (CountOnes),
    .CountTens (CountTens),
    .Running   (Running),
    .Wrap      (Wrap),
    .Seg7Ones  (Seg7Ones),
    .Seg7Tens  (Seg7Tens)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_exp(input int d);
`ifdef BCD_TICK_COUNTER_SEG7_EN
    case (d)
      0: return 7'h3F;
      1: return 7'h06;
      2: return 7'h5B;
      3: return 7'h4F;
      4: return 7'h66;
      5: return 7'h6D;
      6: return 7'h7D;
      7: return 7'h07;
      8: return 7'h7F;
      9: return 7'h6F;
      default: return 7'h00;
    endcase
`else
    return 7'h00 & 7'(d);
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input int tens, input int ones,
                             input logic run, input logic wrap, input bit seg);
    check({tag, ".tens"}, 8'(CountTens), 8'(tens));
    check({tag, ".ones"}, 8'(CountOnes), 8'(ones));
    check({tag, ".running"}, 8'(Running), 8'(run));
    check({tag, ".wrap"}, 8'(Wrap), 8'(wrap));
    if (seg) begin
      check({tag, ".seg_tens"}, 8'(Seg7Tens), 8'(seg_exp(tens)));
      check({tag, ".seg_ones"}, 8'(Seg7Ones), 8'(seg_exp(ones)));
    end
  endtask

  // One full Tick period; the count has settled when it returns.
  task automatic tick();
    Tick = 1'b1;
    repeat (S + 1) @(negedge CLK);
    Tick = 1'b0;
    repeat (S + 1) @(negedge CLK);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Tick with checks at the update cycle (including Wrap) and after settling.
  task automatic tick_watch(input string tag, input int tens, input int ones, input logic wrap);
    Tick = 1'b1;
    repeat (S + 1) @(negedge CLK);
    check_state({tag, "@upd"}, tens, ones, 1'b1, wrap, 1'b0);
    Tick = 1'b0;
    repeat (S + 1) @(negedge CLK);
    check_state({tag, "@settle"}, tens, ones, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
  endtask

  task automatic pulse_pause();
    Pause = 1'b1;
    @(negedge CLK);
    Pause = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge CLK);
    check_state("reset", 0, 0, 1'b0, 1'b0, 1'b1);
    nRST = 1'b1;
    @(negedge CLK);

    // Ticks in IDLE are dropped
    tick();
    check_state("idle_drop", 0, 0, 1'b0, 1'b0, 1'b1);
    pulse_pause();
    check_state("idle_pause", 0, 0, 1'b0, 1'b0, 1'b1);

    pulse_start();
    check_state("start", 0, 0, 1'b1, 1'b0, 1'b1);

    // First tick: count lands S edges after Tick is first sampled; segments one later
    Tick = 1'b1;
    repeat (S) @(negedge CLK);
    check_state("lat_early", 0, 0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    check_state("lat_upd", 0, 1, 1'b1, 1'b0, 1'b0);
    check("lat_seg_lag", 8'(Seg7Ones), 8'(seg_exp(0)));
    @(negedge CLK);
    check("lat_seg_upd", 8'(Seg7Ones), 8'(seg_exp(1)));
    Tick = 1'b0;
    repeat (S + 1) @(negedge CLK);

    ticks(2);
    check_state("count03", 0, 3, 1'b1, 1'b0, 1'b1);

    // Up through the 09 -> 10 carry to 58, 59, then wrap
    ticks(6);
    check_state("count09", 0, 9, 1'b1, 1'b0, 1'b1);
    tick_watch("carry10", 1, 0, 1'b0);
    ticks(48);
    check_state("count58", 5, 8, 1'b1, 1'b0, 1'b1);
    tick_watch("count59", 5, 9, 1'b0);

    Tick = 1'b1;
    repeat (S) @(negedge CLK);
    check_state("upwrap_pre", 5, 9, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    check_state("upwrap_upd", 0, 0, 1'b1, 1'b1, 1'b0);
    check("upwrap_seg_tens_lag", 8'(Seg7Tens), 8'(seg_exp(5)));
    check("upwrap_seg_ones_lag", 8'(Seg7Ones), 8'(seg_exp(9)));
    @(negedge CLK);
    check_state("upwrap_post", 0, 0, 1'b1, 1'b0, 1'b1);
    Tick = 1'b0;
    repeat (S + 1) @(negedge CLK);

    // Down: 10 -> 09 borrow, then 01 -> 00 -> 59 wrap
    ticks(10);
    check_state("count10", 1, 0, 1'b1, 1'b0, 1'b1);
    Down = 1'b1;
    tick_watch("borrow09", 0, 9, 1'b0);
    ticks(8);
    check_state("down01", 0, 1, 1'b1, 1'b0, 1'b1);
    tick_watch("down00", 0, 0, 1'b0);
    tick_watch("downwrap", 5, 9, 1'b1);

    // Direction flip mid-run takes effect from the current value
    Down = 1'b0;
    tick_watch("flip_up_wrap", 0, 0, 1'b1);

    // Pause drops steps; Start resumes
    ticks(7);
    check_state("count07", 0, 7, 1'b1, 1'b0, 1'b1);
    pulse_pause();
    check_state("paused", 0, 7, 1'b0, 1'b0, 1'b1);
    ticks(4);
    check_state("paused_drop", 0, 7, 1'b0, 1'b0, 1'b1);
    pulse_start();
    check_state("resume", 0, 7, 1'b1, 1'b0, 1'b1);
    tick_watch("count08", 0, 8, 1'b0);

    // Start and Pause together in RUN: Pause wins
    Start = 1'b1;
    Pause = 1'b1;
    @(negedge CLK);
    Start = 1'b0;
    Pause = 1'b0;
    check_state("start_pause_run", 0, 8, 1'b0, 1'b0, 1'b1);
    pulse_start();

    // Clear coincident with a step at 59
    ticks(51);
    check_state("count59b", 5, 9, 1'b1, 1'b0, 1'b1);
    Tick = 1'b1;
    repeat (S) @(negedge CLK);
    Clear = 1'b1;
    @(negedge CLK);
    Clear = 1'b0;
    check_state("clear_prio", 0, 0, 1'b0, 1'b0, 1'b0);
    Tick = 1'b0;
    repeat (S + 1) @(negedge CLK);
    check_state("clear_settle", 0, 0, 1'b0, 1'b0, 1'b1);
    pulse_start();
    repeat (2) @(negedge CLK);
    check_state("clear_no_queue", 0, 0, 1'b1, 1'b0, 1'b1);

    // Asynchronous reset mid-count
    ticks(42);
    check_state("count42", 4, 2, 1'b1, 1'b0, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    check_state("async_reset", 0, 0, 1'b0, 1'b0, 1'b1);
    @(negedge CLK);
    nRST = 1'b1;
    @(negedge CLK);
    tick();
    check_state("post_reset_idle", 0, 0, 1'b0, 1'b0, 1'b1);
    pulse_start();
    tick_watch("post_reset_run", 0, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
